// File: rtl/div_unit.sv
// Iterative restoring radix-2 divider for DIV/DIVU that produces one quotient bit per cycle.
// The output is {HI=remainder, LO=quotient}, and ready pulses for one cycle once the result is valid.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_div,
  input  logic               annul,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  output logic [2*WIDTH-1:0] result,
  output logic               ready
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_ZERO = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  logic [CW-1:0]      r_count;
  logic [2*WIDTH-1:0] r_pr;
  logic [WIDTH-1:0]   r_divisor;
  logic               r_sign_q;
  logic               r_sign_r;

  logic [WIDTH:0]     w_top;
  logic               w_ge;
  logic [WIDTH-1:0]   w_sub;
  logic [2*WIDTH-1:0] w_step;
  logic [WIDTH-1:0]   w_abs1;
  logic [WIDTH-1:0]   w_abs2;

  function automatic logic [WIDTH-1:0] neg_if(input logic en, input logic [WIDTH-1:0] v);
    return en ? (~v + WIDTH'(1)) : v;
  endfunction

  // Operand magnitudes; the most negative value maps exactly to 2^(WIDTH-1) as an unsigned value
  always_comb begin
    w_abs1 = neg_if(signed_div & opdata1[WIDTH-1], opdata1);
    w_abs2 = neg_if(signed_div & opdata2[WIDTH-1], opdata2);
  end

  // One restoring step: the (2*WIDTH+1)-bit shifted remainder's upper WIDTH+1 bits are trial-subtracted
  always_comb begin
    w_top = r_pr[2*WIDTH-1:WIDTH-1];
    w_ge  = (w_top >= {1'b0, r_divisor});
    w_sub = w_top[WIDTH-1:0] - r_divisor;
    if (w_ge) begin
      w_step = {w_sub, r_pr[WIDTH-2:0], 1'b1};
    end else begin
      w_step = {r_pr[2*WIDTH-2:0], 1'b0};
    end
  end

  // Control FSM with registered result and ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_pr      <= '0;
      r_divisor <= '0;
      r_sign_q  <= 1'b0;
      r_sign_r  <= 1'b0;
      result    <= '0;
      ready     <= 1'b0;
    end else begin
      ready <= 1'b0;
      if (annul) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_count   <= '0;
              r_divisor <= w_abs2;
              r_sign_q  <= signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
              r_sign_r  <= signed_div & opdata1[WIDTH-1];
              if (opdata2 == '0) begin
                // Divide-by-zero keeps the raw dividend for HI
                r_pr    <= {{WIDTH{1'b0}}, opdata1};
                r_state <= S_ZERO;
              end else begin
                r_pr    <= {{WIDTH{1'b0}}, w_abs1};
                r_state <= S_BUSY;
              end
            end
          end
          S_BUSY: begin
            r_pr    <= w_step;
            r_count <= r_count + CW'(1);
            if (r_count == CW'(WIDTH - 1)) begin
              result  <= {neg_if(r_sign_r, w_step[2*WIDTH-1:WIDTH]),
                          neg_if(r_sign_q, w_step[WIDTH-1:0])};
              r_state <= S_DONE;
            end
          end
          S_ZERO: begin
            result  <= {r_pr[WIDTH-1:0], {WIDTH{1'b1}}};
            r_state <= S_DONE;
          end
          S_DONE: begin
            ready   <= 1'b1;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
